// File: rtl/calc_pkg.sv
// calc_pkg: op codes, FSM states and default datapath width shared by the
// RPN calculator core and its divider.
package calc_pkg;

  localparam int WIDTH_DEFAULT = 16;

  typedef enum logic [2:0] {
    OP_ADD   = 3'd0,
    OP_SUB   = 3'd1,
    OP_MUL   = 3'd2,
    OP_DIV   = 3'd3,
    OP_MOD   = 3'd4,
    OP_POP   = 3'd5,
    OP_CLEAR = 3'd6
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_DIV_RUN = 2'd1,
    ST_ERR     = 2'd2
  } state_e;

  function automatic logic op_is_div(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_MOD);
  endfunction

endpackage

// File: rtl/calc_divider.sv
// calc_divider: sequential restoring divider, one quotient bit per cycle.
// The first bit is resolved on the start edge, so done pulses WIDTH-1 cycles later.
module calc_divider
  import calc_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quotient_o,
  output logic [WIDTH-1:0] remainder_o
);

  localparam int CW = $clog2(WIDTH) + 1;

  logic [WIDTH-1:0]   rem_q;
  logic [WIDTH-1:0]   quo_q;
  logic [WIDTH-1:0]   dvs_q;
  logic [CW-1:0]      cnt_q;
  logic               run_q;
  logic               done_q;
  logic [2*WIDTH-1:0] step_s;

  // One restoring step: shift in the next dividend bit and subtract if it fits.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [WIDTH-1:0] rem,
                                                 input logic [WIDTH-1:0] quo,
                                                 input logic [WIDTH-1:0] dvs);
    logic [WIDTH:0] trial;
    trial = {rem, quo[WIDTH-1]};
    if (trial >= {1'b0, dvs}) begin
      return {WIDTH'(trial - {1'b0, dvs}), quo[WIDTH-2:0], 1'b1};
    end else begin
      return {trial[WIDTH-1:0], quo[WIDTH-2:0], 1'b0};
    end
  endfunction

  always_comb begin
    if (start_i) begin
      step_s = div_step({WIDTH{1'b0}}, dividend_i, divisor_i);
    end else begin
      step_s = div_step(rem_q, quo_q, dvs_q);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (start_i) begin
        {rem_q, quo_q} <= step_s;
        dvs_q          <= divisor_i;
        cnt_q          <= CW'(WIDTH - 1);
        run_q          <= 1'b1;
      end else if (run_q) begin
        {rem_q, quo_q} <= step_s;
        cnt_q          <= cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end
      end
    end
  end

  assign done_o      = done_q;
  assign quotient_o  = quo_q;
  assign remainder_o = rem_q;

endmodule

// File: rtl/calc_core.sv
// calc_core: RPN calculator with a DEPTH-entry operand stack and a multi-cycle divider.
// Build option: define CALC_MUL_EN to support MUL; otherwise MUL is an undefined code.
module calc_core
  import calc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw,
  input  logic             btn_push,
  input  logic             btn_exec,
  input  logic [2:0]       op_sel,
  output logic [WIDTH-1:0] number,
  output logic             error,
  output logic             busy,
  output logic [3:0]       depth
);

  localparam int IW = $clog2(DEPTH);

  state_e           state_q;
  logic [3:0]       depth_q;
  logic [WIDTH-1:0] number_q;
  logic             error_q;
  logic             busy_q;
  logic             div_mod_q;
  logic [WIDTH-1:0] stack_q [DEPTH];

  logic [IW-1:0]    top_idx_s;
  logic [IW-1:0]    below_idx_s;
  logic [IW-1:0]    push_idx_s;
  logic [WIDTH-1:0] a_s;
  logic [WIDTH-1:0] b_s;
  logic [WIDTH-1:0] alu_s;
  logic [WIDTH-1:0] quo_s;
  logic [WIDTH-1:0] rem_s;
  logic [WIDTH-1:0] div_res_s;
  logic             idle_s;
  logic             push_s;
  logic             exec_s;
  logic             full_s;
  logic             has2_s;
  logic             alu_op_s;
  logic             exec_err_s;
  logic             div_start_s;
  logic             div_fin_s;
  logic             div_done_s;
  logic             stack_we_s;
  logic [IW-1:0]    stack_widx_s;
  logic [WIDTH-1:0] stack_wdata_s;

  // a sits below b; indices are only used when depth guarantees they are valid.
  assign top_idx_s   = IW'(depth_q - 4'd1);
  assign below_idx_s = IW'(depth_q - 4'd2);
  assign push_idx_s  = IW'(depth_q);
  assign a_s         = stack_q[below_idx_s];
  assign b_s         = stack_q[top_idx_s];

  assign idle_s = (state_q == ST_IDLE);
  assign push_s = idle_s && btn_push;
  assign exec_s = idle_s && btn_exec && !btn_push;
  assign full_s = (depth_q == 4'(DEPTH));
  assign has2_s = (depth_q >= 4'd2);

  always_comb begin
    alu_op_s   = 1'b0;
    alu_s      = '0;
    exec_err_s = 1'b0;
    case (op_sel)
      OP_ADD: begin
        alu_op_s   = 1'b1;
        alu_s      = a_s + b_s;
        exec_err_s = !has2_s;
      end
      OP_SUB: begin
        alu_op_s   = 1'b1;
        alu_s      = a_s - b_s;
        exec_err_s = !has2_s;
      end
`ifdef CALC_MUL_EN
      OP_MUL: begin
        alu_op_s   = 1'b1;
        alu_s      = a_s * b_s;
        exec_err_s = !has2_s;
      end
`endif
      OP_DIV, OP_MOD: exec_err_s = !has2_s || (b_s == '0);
      OP_POP:         exec_err_s = (depth_q == 4'd0);
      OP_CLEAR:       exec_err_s = 1'b0;
      default:        exec_err_s = 1'b1;
    endcase
  end

  assign div_start_s = exec_s && !exec_err_s && op_is_div(op_sel);
  assign div_done_s  = (state_q == ST_DIV_RUN) && div_fin_s;
  assign div_res_s   = div_mod_q ? rem_s : quo_s;

  calc_divider #(
    .WIDTH (WIDTH)
  ) u_div (
    .clk         (clk),
    .reset       (reset),
    .start_i     (div_start_s),
    .dividend_i  (a_s),
    .divisor_i   (b_s),
    .done_o      (div_fin_s),
    .quotient_o  (quo_s),
    .remainder_o (rem_s)
  );

  // Single stack write port: push, one-cycle ALU result, or divider result.
  always_comb begin
    stack_we_s    = 1'b0;
    stack_widx_s  = push_idx_s;
    stack_wdata_s = sw;
    if (push_s && !full_s) begin
      stack_we_s = 1'b1;
    end else if (exec_s && alu_op_s && !exec_err_s) begin
      stack_we_s    = 1'b1;
      stack_widx_s  = below_idx_s;
      stack_wdata_s = alu_s;
    end else if (div_done_s) begin
      stack_we_s    = 1'b1;
      stack_widx_s  = below_idx_s;
      stack_wdata_s = div_res_s;
    end else begin
      stack_we_s = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (stack_we_s) begin
      stack_q[stack_widx_s] <= stack_wdata_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      depth_q   <= 4'd0;
      number_q  <= '0;
      error_q   <= 1'b0;
      busy_q    <= 1'b0;
      div_mod_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (push_s) begin
            if (full_s) begin
              state_q  <= ST_ERR;
              error_q  <= 1'b1;
              number_q <= '0;
            end else begin
              depth_q  <= depth_q + 4'd1;
              number_q <= sw;
            end
          end else if (exec_s) begin
            if (exec_err_s) begin
              state_q  <= ST_ERR;
              error_q  <= 1'b1;
              number_q <= '0;
            end else begin
              case (op_sel)
                OP_DIV, OP_MOD: begin
                  state_q   <= ST_DIV_RUN;
                  busy_q    <= 1'b1;
                  div_mod_q <= (op_sel == OP_MOD);
                end
                OP_POP: begin
                  depth_q  <= depth_q - 4'd1;
                  number_q <= has2_s ? a_s : '0;
                end
                OP_CLEAR: begin
                  depth_q  <= 4'd0;
                  number_q <= '0;
                end
                default: begin
                  depth_q  <= depth_q - 4'd1;
                  number_q <= alu_s;
                end
              endcase
            end
          end
        end
        ST_DIV_RUN: begin
          if (div_done_s) begin
            state_q  <= ST_IDLE;
            busy_q   <= 1'b0;
            depth_q  <= depth_q - 4'd1;
            number_q <= div_res_s;
          end
        end
        ST_ERR: begin
          if (btn_exec && (op_sel == OP_CLEAR)) begin
            state_q  <= ST_IDLE;
            error_q  <= 1'b0;
            depth_q  <= 4'd0;
            number_q <= '0;
          end
        end
        default: begin
          state_q  <= ST_IDLE;
          error_q  <= 1'b0;
          busy_q   <= 1'b0;
          depth_q  <= 4'd0;
          number_q <= '0;
        end
      endcase
    end
  end

  assign number = number_q;
  assign error  = error_q;
  assign busy   = busy_q;
  assign depth  = depth_q;

endmodule
